// File: rtl/hall_sequence_generator.sv
// ---------------------------------------------------------------------------
// hall_sequence_generator
//
// Emulates the 3-bit Hall-effect sensor code of a BLDC motor. The six
// 120-degree sectors are stepped forward or in reverse at a programmable
// number of clocks per step. It can run continuously, single-step while
// idle, or force the fault codes 000 / 111 onto the Hall output.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-high
//   en           continuous-run enable
//   dir          0 = forward sector order, 1 = reverse sector order
//   period       clocks per Hall step (values below MIN_PERIOD are raised)
//   step_req     single-step request, honoured only while idle
//   fault_sel    00/11 normal, 01 force h = 000, 10 force h = 111
//   h            registered Hall code (h1,h2,h3)
//   sector       registered sector index 0..5
//   step_strobe  one-cycle pulse on every sector change
//   running      high while the sequencer is free-running
// ---------------------------------------------------------------------------
module hall_sequence_generator #(
   parameter int PERIOD_WIDTH = 16,
   parameter int MIN_PERIOD   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    dir,
   input  logic [PERIOD_WIDTH-1:0] period,
   input  logic                    step_req,
   input  logic [1:0]              fault_sel,
   output logic [2:0]              h,
   output logic [2:0]              sector,
   output logic                    step_strobe,
   output logic                    running
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
   localparam logic [PERIOD_WIDTH-1:0] ONE   = PERIOD_WIDTH'(1);

   state_t                  state;
   logic [PERIOD_WIDTH-1:0] count;
   logic [PERIOD_WIDTH-1:0] latched_period;

   logic [PERIOD_WIDTH-1:0] clamped_period;
   logic [PERIOD_WIDTH-1:0] reload_value;
   logic                    do_step;
   logic [2:0]              sector_next;
   logic [2:0]              h_next;

   // Hall code for each sector, h1h2h3.
   function automatic logic [2:0] sector_code(input logic [2:0] s);
      logic [2:0] code;
      case (s)
         3'd0:    code = 3'b101;
         3'd1:    code = 3'b100;
         3'd2:    code = 3'b110;
         3'd3:    code = 3'b010;
         3'd4:    code = 3'b011;
         3'd5:    code = 3'b001;
         default: code = 3'b101;
      endcase
      return code;
   endfunction

   // Modulo-6 sector advance in either direction.
   function automatic logic [2:0] advance(input logic [2:0] s, input logic d);
      logic [2:0] n;
      if (d == 1'b0) begin
         n = (s >= 3'd5) ? 3'd0 : s + 3'd1;
      end else begin
         n = (s == 3'd0 || s > 3'd5) ? 3'd5 : s - 3'd1;
      end
      return n;
   endfunction

   // Requested period raised to the minimum. The reload is one less than the
   // period because the reload edge itself is the first clock of the step;
   // the largest period reloads as all-ones minus one, so nothing overflows.
   always_comb begin
      clamped_period = (period < MIN_P) ? MIN_P : period;
      reload_value   = clamped_period - ONE;
   end

   // A step happens either at the end of a running step (unless en is
   // dropping on that same edge) or on an idle single-step request that is
   // not being overridden by en rising.
   always_comb begin
      do_step = 1'b0;
      if (state == RUN) begin
         do_step = en && (count == '0);
      end else begin
         do_step = !en && step_req;
      end
   end

   // Next sector and the Hall code that goes with it, with the fault codes
   // substituted on the output only; the sector itself keeps tracking.
   always_comb begin
      sector_next = do_step ? advance(sector, dir) : sector;
      case (fault_sel)
         2'b01:   h_next = 3'b000;
         2'b10:   h_next = 3'b111;
         default: h_next = sector_code(sector_next);
      endcase
   end

   // Sequencer FSM. All outputs are registered here so that nothing reaches
   // an output without passing through a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         count          <= '0;
         latched_period <= MIN_P;
         sector         <= 3'd0;
         h              <= 3'b101;
         step_strobe    <= 1'b0;
         running        <= 1'b0;
      end else begin
         sector      <= sector_next;
         h           <= h_next;
         step_strobe <= do_step;
         case (state)
            IDLE: begin
               if (en) begin
                  state          <= RUN;
                  latched_period <= clamped_period;
                  count          <= reload_value;
                  running        <= 1'b1;
               end
            end
            RUN: begin
               if (!en) begin
                  state   <= IDLE;
                  count   <= '0;
                  running <= 1'b0;
               end else if (count == '0) begin
                  latched_period <= clamped_period;
                  count          <= reload_value;
               end else if (count >= latched_period) begin
                  // Never lets the countdown exceed the step in progress.
                  count <= latched_period - ONE;
               end else begin
                  count <= count - ONE;
               end
            end
            default: begin
               state   <= IDLE;
               count   <= '0;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hall_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_hall_sequence_generator
//
// Self-checking bench for hall_sequence_generator. A behavioural model that
// counts remaining clocks per step and walks a sector table is compared with
// the DUT after every clock edge; directed scenarios add literal checks on
// step timing, Hall sequences, single-step, fault codes and async reset.
// ---------------------------------------------------------------------------
module tb_hall_sequence_generator;

   localparam int PW = 16;

   logic          clk;
   logic          rst;
   logic          en;
   logic          dir;
   logic [PW-1:0] period;
   logic          step_req;
   logic [1:0]    fault_sel;
   logic [2:0]    h;
   logic [2:0]    sector;
   logic          step_strobe;
   logic          running;

   hall_sequence_generator #(
      .PERIOD_WIDTH(PW),
      .MIN_PERIOD(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .dir(dir),
      .period(period),
      .step_req(step_req),
      .fault_sel(fault_sel),
      .h(h),
      .sector(sector),
      .step_strobe(step_strobe),
      .running(running)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cycleNum = 0;

   // Hall code per sector, straight from the sector table.
   logic [2:0] codeTable [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

   // Behavioural model state: remaining clocks until the next step.
   bit         mRun = 1'b0;
   int         mSector = 0;
   int         mRem = 0;
   bit         mStrobe = 1'b0;
   logic [2:0] mH = 3'b101;

   // Log of observed steps, filled by the compare process.
   logic [2:0] hLog[$];
   int         sectorLog[$];
   int         timeLog[$];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int clampP(input int p);
      return (p < 2) ? 2 : p;
   endfunction

   function automatic int nextSector(input int s, input bit d);
      return d ? (s + 5) % 6 : (s + 1) % 6;
   endfunction

   // One model edge, using the inputs the DUT sees on that edge.
   task automatic modelEdge();
      mStrobe = 1'b0;
      if (rst) begin
         mRun = 1'b0;
         mSector = 0;
         mRem = 0;
      end else if (mRun) begin
         if (!en) begin
            mRun = 1'b0;
         end else begin
            mRem--;
            if (mRem == 0) begin
               mSector = nextSector(mSector, dir);
               mStrobe = 1'b1;
               mRem = clampP(int'(period));
            end
         end
      end else if (en) begin
         mRun = 1'b1;
         mRem = clampP(int'(period));
      end else if (step_req) begin
         mSector = nextSector(mSector, dir);
         mStrobe = 1'b1;
      end
      if (rst) mH = 3'b101;
      else if (fault_sel == 2'b01) mH = 3'b000;
      else if (fault_sel == 2'b10) mH = 3'b111;
      else mH = codeTable[mSector];
   endtask

   // Compare process: advance the model at each edge, check the DUT 1 unit
   // later, and log every observed step.
   always @(posedge clk) begin
      cycleNum++;
      modelEdge();
      #1;
      checkOutput("h", int'(h), int'(mH));
      checkOutput("sector", int'(sector), mSector);
      checkOutput("step_strobe", int'(step_strobe), int'(mStrobe));
      checkOutput("running", int'(running), int'(mRun));
      if (step_strobe) begin
         hLog.push_back(h);
         sectorLog.push_back(int'(sector));
         timeLog.push_back(cycleNum);
      end
   end

   task automatic applyStimulus(input bit e, input bit d, input int p, input bit s, input int f);
      en = e;
      dir = d;
      period = PW'(p);
      step_req = s;
      fault_sel = 2'(f);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clearLogs();
      hLog.delete();
      sectorLog.delete();
      timeLog.delete();
   endtask

   task automatic pulseStep(input bit d);
      applyStimulus(0, d, 5, 1, 0);
      waitCycles(1);
      applyStimulus(0, d, 5, 0, 0);
      waitCycles(1);
   endtask

   logic [2:0] fwdH [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
   logic [2:0] revH [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

   int c0;

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 10, 0, 0);
      waitCycles(3);
      rst = 1'b0;
      checkOutput("reset_h", int'(h), 5);
      checkOutput("reset_sector", int'(sector), 0);
      checkOutput("reset_running", int'(running), 0);
      checkOutput("reset_strobe", int'(step_strobe), 0);

      // Forward run, period 10.
      clearLogs();
      c0 = cycleNum + 1;
      applyStimulus(1, 0, 10, 0, 0);
      waitCycles(61);
      applyStimulus(0, 0, 10, 0, 0);
      waitCycles(2);
      checkOutput("fwd_steps", hLog.size(), 6);
      for (int i = 0; i < 6 && i < hLog.size(); i++)
         checkOutput($sformatf("fwd_h%0d", i), int'(hLog[i]), int'(fwdH[i]));
      if (timeLog.size() == 6) begin
         checkOutput("fwd_first_delay", timeLog[0] - c0, 10);
         checkOutput("fwd_span", timeLog[5] - timeLog[0], 50);
         checkOutput("fwd_wrap_s5", sectorLog[4], 5);
         checkOutput("fwd_wrap_s0", sectorLog[5], 0);
      end

      // Reverse run from sector 0.
      clearLogs();
      applyStimulus(1, 1, 10, 0, 0);
      waitCycles(61);
      applyStimulus(0, 1, 10, 0, 0);
      waitCycles(2);
      checkOutput("rev_steps", hLog.size(), 6);
      for (int i = 0; i < 6 && i < hLog.size(); i++)
         checkOutput($sformatf("rev_h%0d", i), int'(hLog[i]), int'(revH[i]));
      if (sectorLog.size() == 6) begin
         checkOutput("rev_s0", sectorLog[0], 5);
         checkOutput("rev_s1", sectorLog[1], 4);
      end

      // Period 0 and 1 clamp to two clocks.
      for (int p = 0; p < 2; p++) begin
         clearLogs();
         c0 = cycleNum + 1;
         applyStimulus(1, 0, p, 0, 0);
         waitCycles(9);
         applyStimulus(0, 0, p, 0, 0);
         waitCycles(2);
         checkOutput($sformatf("minp%0d_steps", p), timeLog.size(), 4);
         if (timeLog.size() == 4) begin
            checkOutput($sformatf("minp%0d_first", p), timeLog[0] - c0, 2);
            for (int i = 1; i < 4; i++)
               checkOutput($sformatf("minp%0d_gap%0d", p, i), timeLog[i] - timeLog[i-1], 2);
         end
      end

      // Period change 20 -> 5 mid-step.
      clearLogs();
      c0 = cycleNum + 1;
      applyStimulus(1, 0, 20, 0, 0);
      waitCycles(5);
      applyStimulus(1, 0, 5, 0, 0);
      waitCycles(22);
      applyStimulus(0, 0, 5, 0, 0);
      waitCycles(2);
      checkOutput("pchg_steps", timeLog.size(), 2);
      if (timeLog.size() == 2) begin
         checkOutput("pchg_first", timeLog[0] - c0, 20);
         checkOutput("pchg_second", timeLog[1] - timeLog[0], 5);
      end

      // Single-step: bring the sector to 2, then three pulses forward.
      for (int i = 0; i < 6 && mSector != 2; i++) pulseStep(0);
      checkOutput("ss_start", int'(sector), 2);
      clearLogs();
      for (int i = 0; i < 3; i++) pulseStep(0);
      checkOutput("ss_sector", int'(sector), 5);
      checkOutput("ss_h", int'(h), 1);
      checkOutput("ss_strobes", hLog.size(), 3);

      // step_req held high steps every clock.
      clearLogs();
      applyStimulus(0, 1, 5, 1, 0);
      waitCycles(4);
      applyStimulus(0, 1, 5, 0, 0);
      waitCycles(1);
      checkOutput("ss_held", hLog.size(), 4);

      // step_req with en rising and throughout RUN: only timed steps.
      clearLogs();
      applyStimulus(1, 0, 10, 1, 0);
      waitCycles(25);
      applyStimulus(0, 0, 10, 0, 0);
      waitCycles(2);
      checkOutput("run_stepreq", hLog.size(), 2);

      // Fault overrides during RUN.
      clearLogs();
      applyStimulus(1, 0, 4, 0, 1);
      waitCycles(13);
      checkOutput("fault01_h", int'(h), 0);
      checkOutput("fault01_strobes", hLog.size(), 3);
      applyStimulus(1, 0, 4, 0, 0);
      waitCycles(3);
      applyStimulus(1, 0, 4, 0, 2);
      waitCycles(6);
      checkOutput("fault10_h", int'(h), 7);
      applyStimulus(1, 0, 4, 0, 3);
      waitCycles(3);
      applyStimulus(0, 0, 4, 0, 0);
      waitCycles(2);

      // Randomized stimulus, checked every cycle by the compare process.
      for (int i = 0; i < 600; i++) begin
         en = ($urandom_range(0, 11) == 0) ? ~en : en;
         dir = ($urandom_range(0, 7) == 0) ? ~dir : dir;
         period = ($urandom_range(0, 15) == 0) ? PW'($urandom_range(0, 30)) : PW'($urandom_range(0, 6));
         step_req = 1'($urandom_range(0, 1));
         fault_sel = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         waitCycles(1);
      end
      applyStimulus(0, 0, 6, 0, 0);
      waitCycles(2);

      // Async reset mid-step at sector 3.
      applyStimulus(1, 0, 6, 0, 0);
      for (int i = 0; i < 60; i++) begin
         if (sector == 3'd3 && step_strobe) break;
         @(negedge clk);
      end
      checkOutput("reach_s3", int'(sector), 3);
      waitCycles(2);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_h", int'(h), 5);
      checkOutput("arst_sector", int'(sector), 0);
      checkOutput("arst_running", int'(running), 0);
      checkOutput("arst_strobe", int'(step_strobe), 0);
      applyStimulus(0, 0, 6, 0, 0);
      waitCycles(2);
      rst = 1'b0;
      waitCycles(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
